// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Radix-2 iterative multiply/divide unit owning the HI/LO pair.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             abort_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               is_div_q,  is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q,   bzero_d;
    logic [WIDTH-1:0]   aorig_q,   aorig_d;
    logic [WIDTH-1:0]   opb_q,     opb_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               dz_q,      dz_d;
    logic               done_q,    done_d;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign w_a_neg = ~op_i[0] & a_i[WIDTH-1];
    assign w_b_neg = ~op_i[0] & b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a_i : a_i;
    assign w_b_mag = w_b_neg ? -b_i : b_i;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right
    assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left
    assign w_rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign w_ge       = w_rem_sh >= {1'b0, opb_q};
    assign w_diff     = w_rem_sh[WIDTH-1:0] - opb_q;
    assign w_div_next = w_ge ? {w_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign w_prod = neg_res_q ? -acc_q : acc_q;
    assign w_quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        aorig_d   = aorig_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    is_div_d  = op_i[1];
                    neg_res_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    bzero_d   = (b_i == '0);
                    aorig_d   = a_i;
                    opb_d     = op_i[1] ? w_b_mag : w_a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? w_a_mag : w_b_mag)};
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end else begin
                    if (wr_hi_i) hi_d = wdata_i;
                    if (wr_lo_i) lo_d = wdata_i;
                end
            end
            S_CALC: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? w_div_next : w_mul_next;
                    if (cnt_q == LAST_CNT) state_d = S_FIX;
                    else                   cnt_d   = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d = aorig_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = w_rem;
                    lo_d = w_quo;
                    dz_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            aorig_q   <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            aorig_q   <= aorig_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign dz_o   = dz_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire
